// File: rtl/exec_ctrl_md_if.sv
// -----------------------------------------------------------------------------
// exec_ctrl_md_if
// Groups the ID/EX-side signals of the execute-stage controller into one bundle.
//   master : pipeline side, drives the instruction fields and operands
//   slave  : exec_ctrl_md, drives the decode outputs, stall and M-ext result
// Signals:
//   valid_in, flush         instruction valid / kill current EX instruction
//   alu_op, funct7, funct3  decode fields
//   op_a, op_b              forwarded rs1/rs2 values
//   alu_ctrl, illegal,      combinational decode results
//   is_md
//   stall                   hold IF/ID/EX while an M op iterates
//   md_valid, md_result     registered M-extension result, one-cycle pulse
// -----------------------------------------------------------------------------
interface exec_ctrl_md_if #(
   parameter int XLEN = 32
);
   logic            valid_in;
   logic            flush;
   logic [1:0]      alu_op;
   logic [6:0]      funct7;
   logic [2:0]      funct3;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic [3:0]      alu_ctrl;
   logic            illegal;
   logic            is_md;
   logic            stall;
   logic            md_valid;
   logic [XLEN-1:0] md_result;

   modport master (
      output valid_in, flush, alu_op, funct7, funct3, op_a, op_b,
      input  alu_ctrl, illegal, is_md, stall, md_valid, md_result
   );

   modport slave (
      input  valid_in, flush, alu_op, funct7, funct3, op_a, op_b,
      output alu_ctrl, illegal, is_md, stall, md_valid, md_result
   );
endinterface

// File: rtl/exec_ctrl_md.sv
// -----------------------------------------------------------------------------
// exec_ctrl_md
// Execute-stage control for a 5-stage RV32 pipeline: full RV32I ALU decode plus
// an iterative shift-add multiplier / restoring divider for the M extension.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    exec_ctrl_md_if.slave (decode inputs, operands, decode outputs,
//          stall, md_valid, md_result)
// An M op stalls the pipeline from its issue cycle until the iterations finish,
// then md_result is shown with md_valid for exactly one cycle (state DONE).
// -----------------------------------------------------------------------------
module exec_ctrl_md #(
   parameter int XLEN = 32
) (
   input  logic          clk,
   input  logic          reset,
   exec_ctrl_md_if.slave bus
);
   localparam int CNT_W = $clog2(XLEN);

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MD   = 7'b0000001;

   typedef enum logic [3:0] {
      ALU_AND  = 4'b0000, ALU_OR  = 4'b0001, ALU_ADD = 4'b0010, ALU_XOR = 4'b0011,
      ALU_SLL  = 4'b0100, ALU_SRL = 4'b0101, ALU_SUB = 4'b0110, ALU_SRA = 4'b0111,
      ALU_SLT  = 4'b1000, ALU_SLTU = 4'b1001
   } alu_e;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

   // funct3 table shared by R-type (funct7=0) and I-type
   function automatic alu_e base_op(input logic [2:0] f3);
      alu_e op;
      op = ALU_ADD;
      case (f3)
         3'b000: op = ALU_ADD;
         3'b001: op = ALU_SLL;
         3'b010: op = ALU_SLT;
         3'b011: op = ALU_SLTU;
         3'b100: op = ALU_XOR;
         3'b101: op = ALU_SRL;
         3'b110: op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   // ---------------- ALU decode (purely combinational) ----------------------
   alu_e w_alu_ctrl;
   logic w_illegal;
   logic w_is_md;

   always_comb begin
      // NOTE: defaults first, so every path assigns every output and no latch is inferred.
      w_alu_ctrl = ALU_ADD;
      w_illegal  = 1'b0;
      w_is_md    = (bus.alu_op == 2'b10) && (bus.funct7 == F7_MD);
      case (bus.alu_op)
         2'b00: w_alu_ctrl = ALU_ADD;
         2'b01: w_alu_ctrl = ALU_SUB;
         2'b10: begin
            if (bus.funct7 == F7_BASE)                          w_alu_ctrl = base_op(bus.funct3);
            else if (bus.funct7 == F7_ALT && bus.funct3 == 3'b000) w_alu_ctrl = ALU_SUB;
            else if (bus.funct7 == F7_ALT && bus.funct3 == 3'b101) w_alu_ctrl = ALU_SRA;
            else if (!w_is_md)                                  w_illegal  = 1'b1;
         end
         default: begin
            // I-type: funct7 only matters for the shift encodings
            if (bus.funct3 == 3'b101) begin
               if (bus.funct7 == F7_ALT)       w_alu_ctrl = ALU_SRA;
               else if (bus.funct7 == F7_BASE) w_alu_ctrl = ALU_SRL;
               else                            w_illegal  = 1'b1;
            end else if (bus.funct3 == 3'b001 && bus.funct7 != F7_BASE) begin
               w_illegal = 1'b1;
            end else begin
               w_alu_ctrl = base_op(bus.funct3);
            end
         end
      endcase
   end

   // ---------------- M-extension sequencer ----------------------------------
   state_e            r_state, w_state_next;
   logic [2*XLEN-1:0] r_acc;       // MUL: {partial high, multiplier}; DIV: {remainder, dividend/quotient}
   logic [XLEN-1:0]   r_opb;       // MUL: |multiplicand|; DIV: |divisor|
   logic [CNT_W-1:0]  r_cnt;
   logic              r_neg_main;  // product / quotient must be negated
   logic              r_neg_rem;   // remainder must be negated
   logic              r_sel;       // MUL: take high half; DIV: take remainder
   logic              r_div_zero;
   logic              r_div_ovf;
   logic              r_md_valid;
   logic [XLEN-1:0]   r_md_result;

   logic              w_issue, w_is_div, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
   logic [XLEN-1:0]   w_abs_a, w_abs_b;
   logic              w_last, w_div_special, w_finish;
   logic [XLEN:0]     w_mul_sum;
   logic [2*XLEN-1:0] w_mul_next, w_mul_prod;
   logic              w_div_ge;
   logic [XLEN-1:0]   w_div_sub;
   logic [2*XLEN-1:0] w_div_next;
   logic [XLEN-1:0]   w_quo, w_rem, w_result;

   // Issue is gated by reset so stall reads zero while reset is held.
   assign w_issue    = !reset && (r_state == S_IDLE) && bus.valid_in && w_is_md && !bus.flush;
   assign w_is_div   = bus.funct3[2];
   // MUL/MULH: both signed; MULHSU: a signed only; MULHU: neither. DIV/REM signed, DIVU/REMU not.
   assign w_a_signed = w_is_div ? !bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
   assign w_b_signed = w_is_div ? !bus.funct3[0] : !bus.funct3[1];
   assign w_a_neg    = w_a_signed && bus.op_a[XLEN-1];
   assign w_b_neg    = w_b_signed && bus.op_b[XLEN-1];
   assign w_abs_a    = w_a_neg ? -bus.op_a : bus.op_a;
   assign w_abs_b    = w_b_neg ? -bus.op_b : bus.op_b;

   assign w_last        = (r_cnt == CNT_W'(XLEN - 1));
   assign w_div_special = (r_cnt == '0) && (r_div_zero || r_div_ovf);

   // Shift-add step: add multiplicand into the high half when the multiplier LSB is set.
   assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : {(XLEN+1){1'b0}});
   assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

   // Restoring step: the partial remainder after subtraction always fits XLEN bits,
   // so the low XLEN bits of a modular subtract are exact.
   assign w_div_ge   = r_acc[2*XLEN-1:XLEN-1] >= {1'b0, r_opb};
   assign w_div_sub  = r_acc[2*XLEN-2:XLEN-1] - r_opb;
   assign w_div_next = w_div_ge ? {w_div_sub, r_acc[XLEN-2:0], 1'b1}
                                : {r_acc[2*XLEN-2:0], 1'b0};

   always_comb begin
      w_mul_prod = r_neg_main ? -w_mul_next : w_mul_next;
      w_quo      = r_neg_main ? -w_div_next[XLEN-1:0] : w_div_next[XLEN-1:0];
      w_rem      = r_neg_rem ? -w_div_next[2*XLEN-1:XLEN] : w_div_next[2*XLEN-1:XLEN];
      w_result   = '0;
      if (r_state == S_MUL) begin
         w_result = r_sel ? w_mul_prod[2*XLEN-1:XLEN] : w_mul_prod[XLEN-1:0];
      end else if (r_div_zero && r_cnt == '0) begin
         // r_acc low half is still |op_a|; re-signing it recovers op_a
         w_result = r_sel ? (r_neg_rem ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0]) : '1;
      end else if (r_div_ovf && r_cnt == '0) begin
         // |most-negative| is itself, so the latched magnitude equals op_a
         w_result = r_sel ? '0 : r_acc[XLEN-1:0];
      end else begin
         w_result = r_sel ? w_rem : w_quo;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: if (w_issue) w_state_next = w_is_div ? S_DIV : S_MUL;
         S_MUL:  if (bus.flush) w_state_next = S_IDLE;
                 else if (w_last) w_state_next = S_DONE;
         S_DIV:  if (bus.flush) w_state_next = S_IDLE;
                 else if (w_last || w_div_special) w_state_next = S_DONE;
         default: w_state_next = S_IDLE;
      endcase
   end

   assign w_finish = (r_state == S_MUL || r_state == S_DIV) && (w_state_next == S_DONE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_acc       <= '0;
         r_opb       <= '0;
         r_cnt       <= '0;
         r_neg_main  <= 1'b0;
         r_neg_rem   <= 1'b0;
         r_sel       <= 1'b0;
         r_div_zero  <= 1'b0;
         r_div_ovf   <= 1'b0;
         r_md_valid  <= 1'b0;
         r_md_result <= '0;
      end else begin
         // NOTE: non-blocking everywhere here so every register samples pre-edge values.
         r_md_valid <= 1'b0;
         if (w_issue) begin
            r_acc      <= {{XLEN{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
            r_opb      <= w_is_div ? w_abs_b : w_abs_a;
            r_cnt      <= '0;
            r_neg_main <= w_a_neg ^ w_b_neg;
            r_neg_rem  <= w_a_neg;
            r_sel      <= w_is_div ? bus.funct3[1] : (bus.funct3[1:0] != 2'b00);
            r_div_zero <= (bus.op_b == '0);
            r_div_ovf  <= w_a_signed && (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op_b == '1);
         end else if (r_state == S_MUL) begin
            r_acc <= w_mul_next;
            r_cnt <= r_cnt + CNT_W'(1);
         end else if (r_state == S_DIV) begin
            r_acc <= w_div_next;
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (w_finish) begin
            r_md_result <= w_result;
            r_md_valid  <= 1'b1;
         end
      end
   end

   assign bus.alu_ctrl  = w_alu_ctrl;
   assign bus.illegal   = w_illegal;
   assign bus.is_md     = w_is_md;
   assign bus.stall     = w_issue || (r_state == S_MUL) || (r_state == S_DIV);
   assign bus.md_valid  = r_md_valid;
   assign bus.md_result = r_md_result;
endmodule

// File: tb/tb_exec_ctrl_md.sv
// -----------------------------------------------------------------------------
// tb_exec_ctrl_md
// Directed bench for exec_ctrl_md (XLEN=32). Decode results are compared right
// after the inputs settle; M-op results are pushed to a scoreboard queue when
// issued and popped by a monitor whenever md_valid is seen.
// -----------------------------------------------------------------------------
module tb_exec_ctrl_md;
   localparam int XLEN = 32;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   exec_ctrl_md_if #(.XLEN(XLEN)) bus ();
   exec_ctrl_md #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus));

   int n_pass  = 0;
   int n_total = 0;
   logic [XLEN-1:0] exp_q[$];
   string           name_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Monitor: every md_valid pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      if (bus.md_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("md_valid with nothing pending", bus.md_valid, 1'b0);
         end else begin
            string nm;
            nm = name_q.pop_front();
            check(nm, bus.md_result, exp_q.pop_front());
         end
      end
   end

   task automatic dec(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                      input logic [3:0] ctrl, input logic ill, input logic md);
      string nm;
      nm = $sformatf("dec %b/%b/%b", op, f7, f3);
      bus.alu_op = op;
      bus.funct7 = f7;
      bus.funct3 = f3;
      #1;
      if (!md) check({nm, " alu_ctrl"}, bus.alu_ctrl, ctrl);
      check({nm, " illegal"}, bus.illegal, ill);
      check({nm, " is_md"}, bus.is_md, md);
   endtask

   task automatic drive_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      bus.alu_op   = 2'b10;
      bus.funct7   = 7'b0000001;
      bus.funct3   = f3;
      bus.op_a     = a;
      bus.op_b     = b;
      bus.flush    = 1'b0;
      bus.valid_in = 1'b1;
      #1;
   endtask

   // Issue one M op, count stall cycles, check the single md_valid pulse.
   task automatic do_md(input string nm, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
      int cycles;
      cycles = 0;
      exp_q.push_back(exp);
      name_q.push_back(nm);
      drive_md(f3, a, b);
      while (bus.stall === 1'b1 && cycles < 200) begin
         @(posedge clk); #1;
         cycles++;
      end
      check({nm, " stall cycles"}, cycles, lat);
      check({nm, " md_valid in DONE"}, bus.md_valid, 1'b1);
      bus.valid_in = 1'b0;
      @(posedge clk); #1;
      check({nm, " md_valid one pulse"}, bus.md_valid, 1'b0);
      check({nm, " md_result held"}, bus.md_result, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] rtab [8];
      rtab = '{4'h2, 4'h4, 4'h8, 4'h9, 4'h3, 4'h5, 4'h1, 4'h0};

      reset        = 1'b1;
      bus.valid_in = 1'b0;
      bus.flush    = 1'b0;
      bus.alu_op   = 2'b00;
      bus.funct7   = 7'b0;
      bus.funct3   = 3'b0;
      bus.op_a     = '0;
      bus.op_b     = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset stall", bus.stall, 1'b0);
      check("reset md_valid", bus.md_valid, 1'b0);
      check("reset md_result", bus.md_result, 32'h0);
      reset = 1'b0;
      @(posedge clk); #1;

      // ---- decode ----
      dec(2'b00, 7'h7f, 3'b111, 4'h2, 1'b0, 1'b0);
      dec(2'b01, 7'h00, 3'b000, 4'h6, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) dec(2'b10, 7'h00, 3'(i), rtab[i], 1'b0, 1'b0);
      dec(2'b10, 7'h20, 3'b000, 4'h6, 1'b0, 1'b0);
      dec(2'b10, 7'h20, 3'b101, 4'h7, 1'b0, 1'b0);
      dec(2'b10, 7'h20, 3'b001, 4'h2, 1'b1, 1'b0);
      dec(2'b10, 7'h03, 3'b000, 4'h2, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) dec(2'b10, 7'h01, 3'(i), 4'h0, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) dec(2'b11, 7'h00, 3'(i), rtab[i], 1'b0, 1'b0);
      dec(2'b11, 7'h7f, 3'b000, 4'h2, 1'b0, 1'b0);
      dec(2'b11, 7'h20, 3'b101, 4'h7, 1'b0, 1'b0);
      dec(2'b11, 7'h7f, 3'b101, 4'h2, 1'b1, 1'b0);
      dec(2'b11, 7'h20, 3'b001, 4'h2, 1'b1, 1'b0);
      dec(2'b11, 7'h55, 3'b110, 4'h1, 1'b0, 1'b0);
      dec(2'b11, 7'h01, 3'b011, 4'h9, 1'b0, 1'b0);

      // ---- multiply family ----
      do_md("MULH min*min",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
      do_md("MULHU max*max",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
      do_md("MUL -3*7",       3'b000, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 33);
      do_md("MULHSU -1*umax", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);

      // ---- divide family ----
      do_md("DIV -7/2",       3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33);
      do_md("REM -7/2",       3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33);
      do_md("DIVU umax/3",    3'b101, 32'hFFFFFFFF, 32'h00000003, 32'h55555555, 33);
      do_md("DIVU 100/0",     3'b101, 32'd100,      32'h0,        32'hFFFFFFFF, 2);
      do_md("REMU 100/0",     3'b111, 32'd100,      32'h0,        32'd100,      2);
      do_md("REM -7/0",       3'b110, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 2);
      do_md("DIV min/-1",     3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2);
      do_md("REM min/-1",     3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2);

      // ---- flush during the 10th DIV iteration ----
      drive_md(3'b100, 32'd1000, 32'd7);
      repeat (10) begin @(posedge clk); #1; end
      bus.flush = 1'b1;
      #1;
      check("flush: stall before edge", bus.stall, 1'b1);
      @(posedge clk); #1;
      bus.flush    = 1'b0;
      bus.valid_in = 1'b0;
      #1;
      check("flush: stall dropped", bus.stall, 1'b0);
      check("flush: no md_valid", bus.md_valid, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      do_md("MUL 6*7 after flush", 3'b000, 32'd6, 32'd7, 32'd42, 33);

      // ---- async reset in the middle of a MUL ----
      drive_md(3'b011, 32'd5, 32'd9);
      repeat (5) begin @(posedge clk); #1; end
      reset = 1'b1;
      #1;
      check("reset mid-MUL stall", bus.stall, 1'b0);
      check("reset mid-MUL md_valid", bus.md_valid, 1'b0);
      check("reset mid-MUL md_result", bus.md_result, 32'h0);
      bus.valid_in = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      do_md("MULHU 2*3 after reset", 3'b011, 32'd2, 32'd3, 32'h0, 33);

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
